// File: rtl/sum_compare_pipe_if.sv
// Operand/result handshake bundle for sum_compare_pipe.
// The master drives operand sets and accepts results; the slave is the compare pipeline.
interface sum_compare_pipe_if #(
  parameter int W     = 3,
  parameter int N_OPS = 2
);
  localparam int SW = W + $clog2(N_OPS);

  logic               in_valid;
  logic               in_ready;
  logic [N_OPS*W-1:0] in_a;
  logic [N_OPS*W-1:0] in_b;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic               out_res;
  logic [SW-1:0]      out_sum_a;
  logic [SW-1:0]      out_sum_b;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_res, out_sum_a, out_sum_b
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_res, out_sum_a, out_sum_b
  );
endinterface

// File: rtl/sum_compare_pipe.sv
// Two-stage pipelined compare of sum(A operands) against sum(B operands), with a saturating hit counter.
// Define APPROX_LSB_EN to drop TRUNC LSBs of every operand before summation.
module sum_compare_pipe #(
  parameter int W     = 3,
  parameter int N_OPS = 2,
  parameter int CNT_W = 16,
  parameter int TRUNC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sum_compare_pipe_if.slave     bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      hit_cnt
);
  localparam int SW = W + $clog2(N_OPS);
`ifdef APPROX_LSB_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  // Operands are shifted down before the adder so the dropped bits never reach it.
  localparam int DROP = APPROX ? TRUNC : 0;

  typedef enum logic [1:0] {
    MODE_GT = 2'b00,
    MODE_GE = 2'b01,
    MODE_EQ = 2'b10,
    MODE_LT = 2'b11
  } mode_e;

  logic          s1_valid, s2_valid;
  logic [SW-1:0] s1_sum_a, s1_sum_b, s2_sum_a, s2_sum_b;
  mode_e         s1_mode;
  logic          s2_res;
  logic          s1_en, s2_en;
  logic [SW-1:0] part_a, part_b, sum_a_c, sum_b_c;
  logic          cmp_c;

  // Handshake: a transfer happens on a rising edge where valid && ready; a stage
  // advances when it is empty or its successor advances, so ready never depends on valid.
  assign s2_en        = !s2_valid || bus.out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  always_comb begin
    part_a = '0;
    part_b = '0;
    for (int i = 0; i < N_OPS; i++) begin
      part_a = part_a + SW'(bus.in_a[i*W +: W] >> DROP);
      part_b = part_b + SW'(bus.in_b[i*W +: W] >> DROP);
    end
    sum_a_c = part_a << DROP;
    sum_b_c = part_b << DROP;
  end

  always_comb begin
    cmp_c = 1'b0;
    case (s1_mode)
      MODE_GT: cmp_c = s1_sum_a >  s1_sum_b;
      MODE_GE: cmp_c = s1_sum_a >= s1_sum_b;
      MODE_EQ: cmp_c = s1_sum_a == s1_sum_b;
      MODE_LT: cmp_c = s1_sum_a <  s1_sum_b;
      default: cmp_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum_a <= '0;
      s1_sum_b <= '0;
      s1_mode  <= MODE_GT;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum_a <= sum_a_c;
        s1_sum_b <= sum_b_c;
        s1_mode  <= mode_e'(bus.in_mode);
      end
    end
  end

  // Data only loads with a valid set, so held results stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= 1'b0;
      s2_sum_a <= '0;
      s2_sum_b <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res   <= cmp_c;
        s2_sum_a <= s1_sum_a;
        s2_sum_b <= s1_sum_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clr) begin
      hit_cnt <= '0;
    end else if (s2_valid && bus.out_ready && s2_res && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_res   = s2_res;
  assign bus.out_sum_a = s2_sum_a;
  assign bus.out_sum_b = s2_sum_b;
endmodule

// File: tb/tb_sum_compare_pipe.sv
// Bench for sum_compare_pipe (W=3, N_OPS=2, CNT_W=4, TRUNC=1): table vectors, corner sequences,
// random traffic with random backpressure; results checked against an expected queue.
module tb_sum_compare_pipe;
  localparam int W     = 3;
  localparam int N     = 2;
  localparam int SW    = W + $clog2(N);
  localparam int CNT_W = 4;
  localparam int EW    = 2*SW + 1;

  typedef struct {
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [1:0]     mode;
    logic [EW-1:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] hit_cnt;

  sum_compare_pipe_if #(.W(W), .N_OPS(N)) bus ();

  sum_compare_pipe #(.W(W), .N_OPS(N), .CNT_W(CNT_W), .TRUNC(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .cnt_clr (cnt_clr),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_hit = '0;
  vec_t tbl[10];
  bit rnd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, b0, b1, input logic [1:0] m,
                              input int res, sa, sb);
    vec_t v;
    v.a    = {W'(a1), W'(a0)};
    v.b    = {W'(b1), W'(b0)};
    v.mode = m;
    v.exp  = {1'(res), SW'(sa), SW'(sb)};
    return v;
  endfunction

  function automatic logic [EW-1:0] model(input logic [N*W-1:0] a, b, input logic [1:0] m);
    int sa = 0;
    int sb = 0;
    int va, vb;
    logic r;
    for (int i = 0; i < N; i++) begin
      va = int'(a[i*W +: W]);
      vb = int'(b[i*W +: W]);
`ifdef APPROX_LSB_EN
      va = va - (va % 2);
      vb = vb - (vb % 2);
`endif
      sa += va;
      sb += vb;
    end
    case (m)
      2'b00:   r = sa >  sb;
      2'b01:   r = sa >= sb;
      2'b10:   r = sa == sb;
      default: r = sa <  sb;
    endcase
    return {r, SW'(sa), SW'(sb)};
  endfunction

  // Monitor: at the falling edge the values that the next rising edge will act on are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_hit = '0;
    end else begin
      check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          check("out_res", 32'(bus.out_res), 32'(exp_q[0][EW-1]));
          check("out_sum_a", 32'(bus.out_sum_a), 32'(exp_q[0][2*SW-1:SW]));
          check("out_sum_b", 32'(bus.out_sum_b), 32'(exp_q[0][SW-1:0]));
        end
      end
      if (cnt_clr) exp_hit = '0;
      else if (bus.out_valid && bus.out_ready && exp_q.size() != 0 && exp_q[0][EW-1] &&
               exp_hit != {CNT_W{1'b1}}) exp_hit = exp_hit + 1'b1;
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic [N*W-1:0] a, b, input logic [1:0] m, input logic [EW-1:0] e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = m;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    logic [N*W-1:0] ra, rb;
    logic [1:0] rm;
    logic [N*W-1:0] t0 = '0;
    logic [EW-1:0] true_exp;

`ifdef APPROX_LSB_EN
    tbl[0] = mk(3, 2, 1, 3, 2'b00, 1, 4, 2);
    tbl[1] = mk(7, 7, 7, 7, 2'b00, 0, 12, 12);
    tbl[2] = mk(7, 7, 7, 7, 2'b01, 1, 12, 12);
    tbl[3] = mk(7, 7, 7, 7, 2'b10, 1, 12, 12);
    tbl[4] = mk(7, 7, 7, 7, 2'b11, 0, 12, 12);
    tbl[5] = mk(1, 1, 0, 1, 2'b00, 0, 0, 0);
    tbl[6] = mk(0, 0, 7, 7, 2'b11, 1, 0, 12);
    tbl[7] = mk(7, 6, 6, 7, 2'b10, 1, 12, 12);
    tbl[8] = mk(0, 1, 0, 0, 2'b00, 0, 0, 0);
    tbl[9] = mk(4, 3, 5, 3, 2'b01, 1, 6, 6);
`else
    tbl[0] = mk(3, 2, 1, 3, 2'b00, 1, 5, 4);
    tbl[1] = mk(7, 7, 7, 7, 2'b00, 0, 14, 14);
    tbl[2] = mk(7, 7, 7, 7, 2'b01, 1, 14, 14);
    tbl[3] = mk(7, 7, 7, 7, 2'b10, 1, 14, 14);
    tbl[4] = mk(7, 7, 7, 7, 2'b11, 0, 14, 14);
    tbl[5] = mk(1, 1, 0, 1, 2'b00, 1, 2, 1);
    tbl[6] = mk(0, 0, 7, 7, 2'b11, 1, 0, 14);
    tbl[7] = mk(7, 6, 6, 7, 2'b10, 1, 13, 13);
    tbl[8] = mk(0, 1, 0, 0, 2'b00, 1, 1, 0);
    tbl[9] = mk(4, 3, 5, 3, 2'b01, 0, 7, 8);
`endif
    true_exp = {1'b1, SW'(0), SW'(0)};

    // Reset state
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_res", 32'(bus.out_res), 32'd0);
    check("rst_sum_a", 32'(bus.out_sum_a), 32'd0);
    check("rst_sum_b", 32'(bus.out_sum_b), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency of a single set
    send(tbl[0].a, tbl[0].b, tbl[0].mode, tbl[0].exp);
    @(negedge clk);
    check("lat_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    wait_drain();
    check("hit_after_first", 32'(hit_cnt), 32'd1);

    // Remaining table vectors back-to-back at full throughput
    hits = int'(tbl[0].exp[EW-1]);
    for (int i = 1; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].exp);
      hits += int'(tbl[i].exp[EW-1]);
    end
    wait_drain();
    check("hit_after_table", 32'(hit_cnt), 32'(hits));

    // Backpressure: two sets held, third kept out until release
    bus.out_ready = 1'b0;
    send(tbl[0].a, tbl[0].b, tbl[0].mode, tbl[0].exp);
    send(tbl[1].a, tbl[1].b, tbl[1].mode, tbl[1].exp);
    bus.in_valid = 1'b1; bus.in_a = tbl[2].a; bus.in_b = tbl[2].b; bus.in_mode = tbl[2].mode;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(tbl[2].a, tbl[2].b, tbl[2].mode, tbl[2].exp);
    wait_drain();

    // Random traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          ra = N*W'($urandom_range(0, (1 << (N*W)) - 1));
          rb = N*W'($urandom_range(0, (1 << (N*W)) - 1));
          rm = 2'($urandom_range(0, 3));
          send(ra, rb, rm, model(ra, rb, rm));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // Saturation with 20 true results
    for (int i = 0; i < 20; i++) send(t0, t0, 2'b01, true_exp);
    wait_drain();
    check("hit_saturated", 32'(hit_cnt), 32'd15);

    // Reset with two sets in flight
    bus.out_ready = 1'b0;
    send(t0, t0, 2'b01, true_exp);
    send(t0, t0, 2'b10, true_exp);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Clear wins over a simultaneous hit
    for (int i = 0; i < 3; i++) send(t0, t0, 2'b01, true_exp);
    wait_drain();
    check("hit_before_clr", 32'(hit_cnt), 32'd3);
    send(t0, t0, 2'b10, true_exp);
    @(posedge clk); #1;
    check("clr_out_valid", 32'(bus.out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_priority", 32'(hit_cnt), 32'd0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
